// File: rtl/tx_ser_pkg.sv
// tx_ser_pkg: shared types and helpers for the block-to-symbol serializer.
//   ser_state_e : serializer FSM states (CSUM exists only with TX_SER_CHECKSUM_EN)
//   sym_count() : symbols per block, N = BLOCK_W / SYM_W
//   params_ok() : legality of a BLOCK_W / SYM_W / DEPTH combination
// Configuration macro: TX_SER_CHECKSUM_EN (adds the trailing XOR checksum symbol).
package tx_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef TX_SER_CHECKSUM_EN
    , CSUM
`endif
  } ser_state_e;

  function automatic int unsigned sym_count(input int unsigned block_w,
                                            input int unsigned sym_w);
    return block_w / sym_w;
  endfunction

  function automatic bit params_ok(input int unsigned block_w,
                                   input int unsigned sym_w,
                                   input int unsigned depth);
    return (sym_w != 0) && (block_w >= sym_w) && ((block_w % sym_w) == 0) &&
           (depth >= 1);
  endfunction

endpackage

// File: rtl/tx_block_fifo.sv
// tx_block_fifo: DEPTH-entry block FIFO feeding the serializer.
//   clock, resetn  : rising-edge clock, synchronous active-low reset
//   flush          : synchronous clear (pointers and count)
//   push/push_data : write one block (ignored when full or flushing)
//   pop            : drop the head entry (ignored when empty or flushing)
//   head           : current head entry
//   full/empty     : registered status
//   count          : entries held, 0..DEPTH
module tx_block_fifo #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [BLOCK_W-1:0]           push_data,
  input  logic                         pop,
  output logic [BLOCK_W-1:0]           head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      cnt;
  logic               do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tx_block_serializer.sv
// tx_block_serializer: buffers up to DEPTH blocks and emits each one as
// BLOCK_W/SYM_W symbols, LSB symbol first, over a valid/ready handshake.
//   clock, resetn       : rising-edge clock, synchronous active-low reset
//   flush               : synchronous clear of FIFO and serializer
//   blk_valid/blk_ready : block input handshake, blk_data the block
//   sym_valid/sym_ready : symbol output handshake, sym_data the symbol
//   sym_first/sym_last  : framing flags for the current symbol
//   blk_count           : blocks waiting in the FIFO (excludes the one in flight)
// Configuration macro: TX_SER_CHECKSUM_EN appends an XOR checksum symbol per block.
module tx_block_serializer
  import tx_ser_pkg::*;
#(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic                        blk_valid,
  input  logic [BLOCK_W-1:0]          blk_data,
  output logic                        blk_ready,
  output logic                        sym_valid,
  output logic [SYM_W-1:0]            sym_data,
  output logic                        sym_first,
  output logic                        sym_last,
  input  logic                        sym_ready,
  output logic [$clog2(DEPTH+1)-1:0]  blk_count
);

  localparam int unsigned N  = sym_count(BLOCK_W, SYM_W);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  if (!params_ok(BLOCK_W, SYM_W, DEPTH)) begin : g_param_check
    $error("tx_block_serializer: BLOCK_W must be a multiple of SYM_W and DEPTH >= 1");
  end

  ser_state_e         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [BLOCK_W-1:0] fifo_head;
  logic               fifo_full, fifo_empty, pop, load_next;
`ifdef TX_SER_CHECKSUM_EN
  logic [SYM_W-1:0]   csum_q, csum_d;
`endif

  // Ready depends only on registered FIFO status plus the reset/flush inputs.
  assign blk_ready = resetn && !flush && !fifo_full;

  tx_block_fifo #(
    .BLOCK_W (BLOCK_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (flush),
    .push      (blk_valid && blk_ready),
    .push_data (blk_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (blk_count)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
`ifdef TX_SER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
`ifdef TX_SER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    load_next = 1'b0;
`ifdef TX_SER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      IDLE: if (!fifo_empty) load_next = 1'b1;
      SEND: if (sym_ready) begin
`ifdef TX_SER_CHECKSUM_EN
        csum_d = csum_q ^ shreg_q[SYM_W-1:0];
`endif
        if (idx_q != IW'(N - 1)) begin
          shreg_d = shreg_q >> SYM_W;
          idx_d   = idx_q + IW'(1);
        end else begin
`ifdef TX_SER_CHECKSUM_EN
          state_d = CSUM;
`else
          if (!fifo_empty) load_next = 1'b1;
          else             state_d   = IDLE;
`endif
        end
      end
`ifdef TX_SER_CHECKSUM_EN
      CSUM: if (sym_ready) begin
        if (!fifo_empty) load_next = 1'b1;
        else             state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Loading the next block straight from SEND/CSUM avoids an idle bubble.
    if (load_next) begin
      shreg_d = fifo_head;
      idx_d   = '0;
      state_d = SEND;
      pop     = 1'b1;
`ifdef TX_SER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      pop     = 1'b0;
    end
  end

  always_comb begin
    sym_valid = 1'b0;
    sym_data  = '0;
    sym_first = 1'b0;
    sym_last  = 1'b0;
    unique case (state_q)
      SEND: begin
        sym_valid = 1'b1;
        sym_data  = shreg_q[SYM_W-1:0];
        sym_first = (idx_q == '0);
`ifndef TX_SER_CHECKSUM_EN
        sym_last  = (idx_q == IW'(N - 1));
`endif
      end
`ifdef TX_SER_CHECKSUM_EN
      CSUM: begin
        sym_valid = 1'b1;
        sym_data  = csum_q;
        sym_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_block_serializer.sv
module tb_tx_block_serializer;

`ifdef TX_SER_CHECKSUM_EN
  localparam int NS = 17;
`else
  localparam int NS = 16;
`endif

  logic         clock = 1'b0;
  logic         resetn, flush, blk_valid, blk_ready;
  logic [127:0] blk_data;
  logic         sym_valid, sym_first, sym_last, sym_ready;
  logic [7:0]   sym_data;
  logic [1:0]   blk_count;

  int vec  = 0;
  int miss = 0;

  always #5 clock = ~clock;

  tx_block_serializer #(.BLOCK_W(128), .SYM_W(8), .DEPTH(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (flush),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .sym_first (sym_first),
    .sym_last  (sym_last),
    .sym_ready (sym_ready),
    .blk_count (blk_count)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Symbol k of a block as it should appear on the wire (k == 16 is the checksum).
  function automatic logic [7:0] exp_sym(input logic [127:0] b, input int k);
    logic [7:0] x;
    x = '0;
    if (k < 16) return b[k*8 +: 8];
    for (int i = 0; i < 16; i++) x ^= b[i*8 +: 8];
    return x;
  endfunction

  task automatic test_reset;
    resetn = 1'b0; flush = 1'b0; blk_valid = 1'b0; blk_data = '0; sym_ready = 1'b0;
    step; step;
    vec++; if (sym_valid !== 1'b0) begin miss++; $display("FAIL reset_valid got %b exp 0", sym_valid); end
    vec++; if (sym_data !== 8'h00) begin miss++; $display("FAIL reset_data got %h exp 00", sym_data); end
    vec++; if (sym_first !== 1'b0 || sym_last !== 1'b0) begin miss++; $display("FAIL reset_flags got %b%b exp 00", sym_first, sym_last); end
    vec++; if (blk_count !== 2'd0) begin miss++; $display("FAIL reset_count got %0d exp 0", blk_count); end
    vec++; if (blk_ready !== 1'b0) begin miss++; $display("FAIL reset_ready_low got %b exp 0", blk_ready); end
    resetn = 1'b1;
    #1;
    vec++; if (blk_ready !== 1'b1) begin miss++; $display("FAIL reset_ready_high got %b exp 1", blk_ready); end
  endtask

  task automatic test_single;
    logic [127:0] blk;
    blk = 128'h00112233445566778899aabbccddeeff;
    sym_ready = 1'b1; blk_valid = 1'b1; blk_data = blk;
    step;
    blk_valid = 1'b0;
    vec++; if (sym_valid !== 1'b0) begin miss++; $display("FAIL single_latency_idle got %b exp 0", sym_valid); end
    vec++; if (blk_count !== 2'd1) begin miss++; $display("FAIL single_count_queued got %0d exp 1", blk_count); end
    step;
    vec++; if (sym_data !== 8'hff) begin miss++; $display("FAIL single_sym0 got %h exp ff", sym_data); end
    for (int k = 0; k < NS; k++) begin
      vec++; if (sym_valid !== 1'b1 || sym_data !== exp_sym(blk, k)) begin
        miss++; $display("FAIL single_sym%0d got v=%b %h exp v=1 %h", k, sym_valid, sym_data, exp_sym(blk, k)); end
      vec++; if (sym_first !== (k == 0) || sym_last !== (k == NS-1)) begin
        miss++; $display("FAIL single_flags%0d got %b%b exp %b%b", k, sym_first, sym_last, k == 0, k == NS-1); end
      step;
    end
    vec++; if (sym_valid !== 1'b0) begin miss++; $display("FAIL single_end_idle got %b exp 0", sym_valid); end
  endtask

  task automatic test_backpressure;
    logic [127:0] blk;
    blk = 128'h00112233445566778899aabbccddeeff;
    sym_ready = 1'b1; blk_valid = 1'b1; blk_data = blk;
    step;
    blk_valid = 1'b0;
    step;
    for (int k = 0; k < NS; k++) begin
      vec++; if (sym_valid !== 1'b1 || sym_data !== exp_sym(blk, k)) begin
        miss++; $display("FAIL bp_sym%0d got v=%b %h exp v=1 %h", k, sym_valid, sym_data, exp_sym(blk, k)); end
      if (k == 3) begin
        sym_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step;
          vec++; if (sym_valid !== 1'b1 || sym_data !== 8'hcc || sym_first !== 1'b0 || sym_last !== 1'b0) begin
            miss++; $display("FAIL bp_hold%0d got v=%b %h f=%b l=%b exp v=1 cc f=0 l=0", s, sym_valid, sym_data, sym_first, sym_last); end
        end
        sym_ready = 1'b1;
      end
      step;
    end
    vec++; if (sym_valid !== 1'b0) begin miss++; $display("FAIL bp_end_idle got %b exp 0", sym_valid); end
  endtask

  task automatic test_fill;
    logic [127:0] blks [3];
    blks[0] = 128'h0f0e0d0c0b0a09080706050403020100;
    blks[1] = 128'h1f1e1d1c1b1a19181716151413121110;
    blks[2] = 128'h2f2e2d2c2b2a29282726252423222120;
    sym_ready = 1'b0;
    blk_valid = 1'b1; blk_data = blks[0];
    step;                          // A accepted
    blk_data = blks[1];
    step;                          // A loaded into shifter, B accepted
    vec++; if (blk_count !== 2'd1) begin miss++; $display("FAIL fill_count_b got %0d exp 1", blk_count); end
    blk_data = blks[2];
    step;                          // C accepted
    vec++; if (blk_count !== 2'd2) begin miss++; $display("FAIL fill_count_c got %0d exp 2", blk_count); end
    vec++; if (blk_ready !== 1'b0) begin miss++; $display("FAIL fill_ready_full got %b exp 0", blk_ready); end
    blk_data = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    step; step;
    vec++; if (blk_count !== 2'd2) begin miss++; $display("FAIL fill_fourth_rejected got %0d exp 2", blk_count); end
    blk_valid = 1'b0;
    sym_ready = 1'b1;
    for (int k = 0; k < 3*NS; k++) begin
      vec++; if (sym_valid !== 1'b1 || sym_data !== exp_sym(blks[k / NS], k % NS)) begin
        miss++; $display("FAIL fill_sym%0d got v=%b %h exp v=1 %h", k, sym_valid, sym_data, exp_sym(blks[k / NS], k % NS)); end
      vec++; if (sym_first !== (k % NS == 0) || sym_last !== (k % NS == NS-1)) begin
        miss++; $display("FAIL fill_flags%0d got %b%b exp %b%b", k, sym_first, sym_last, k % NS == 0, k % NS == NS-1); end
      if (k == NS) begin
        vec++; if (blk_count !== 2'd1) begin miss++; $display("FAIL fill_count_mid1 got %0d exp 1", blk_count); end
      end
      if (k == 2*NS) begin
        vec++; if (blk_count !== 2'd0) begin miss++; $display("FAIL fill_count_mid2 got %0d exp 0", blk_count); end
      end
      step;
    end
    vec++; if (sym_valid !== 1'b0 || blk_count !== 2'd0) begin
      miss++; $display("FAIL fill_end got v=%b cnt=%0d exp v=0 cnt=0", sym_valid, blk_count); end
  endtask

  task automatic test_flush;
    logic [127:0] e;
    e = 128'h8f8e8d8c8b8a89888786858483828180;
    sym_ready = 1'b1;
    blk_valid = 1'b1; blk_data = 128'h0f0e0d0c0b0a09080706050403020100;
    step;
    blk_data = 128'h1f1e1d1c1b1a19181716151413121110;
    step;
    blk_valid = 1'b0;
    vec++; if (sym_data !== 8'h00 || blk_count !== 2'd1) begin
      miss++; $display("FAIL flush_pre got %h cnt=%0d exp 00 cnt=1", sym_data, blk_count); end
    repeat (7) step;
    vec++; if (sym_data !== 8'h07) begin miss++; $display("FAIL flush_at_sym7 got %h exp 07", sym_data); end
    flush = 1'b1; blk_valid = 1'b1; blk_data = {16{8'hcc}};
    #1;
    vec++; if (blk_ready !== 1'b0) begin miss++; $display("FAIL flush_ready got %b exp 0", blk_ready); end
    step;
    flush = 1'b0; blk_valid = 1'b0;
    vec++; if (sym_valid !== 1'b0 || blk_count !== 2'd0 || sym_data !== 8'h00) begin
      miss++; $display("FAIL flush_cleared got v=%b cnt=%0d %h exp v=0 cnt=0 00", sym_valid, blk_count, sym_data); end
    step;
    vec++; if (sym_valid !== 1'b0 || blk_count !== 2'd0) begin
      miss++; $display("FAIL flush_no_accept got v=%b cnt=%0d exp v=0 cnt=0", sym_valid, blk_count); end
    blk_valid = 1'b1; blk_data = e;
    step;
    blk_valid = 1'b0;
    step;
    for (int k = 0; k < NS; k++) begin
      vec++; if (sym_valid !== 1'b1 || sym_data !== exp_sym(e, k)) begin
        miss++; $display("FAIL flush_new_sym%0d got v=%b %h exp v=1 %h", k, sym_valid, sym_data, exp_sym(e, k)); end
      step;
    end
    vec++; if (sym_valid !== 1'b0) begin miss++; $display("FAIL flush_new_end got %b exp 0", sym_valid); end
  endtask

  task automatic test_reset_mid;
    sym_ready = 1'b1;
    blk_valid = 1'b1; blk_data = 128'h4f4e4d4c4b4a49484746454443424140;
    step;
    blk_data = 128'h5f5e5d5c5b5a59585756555453525150;
    step;
    blk_valid = 1'b0;
    step;
    vec++; if (sym_valid !== 1'b1 || sym_data !== 8'h41) begin
      miss++; $display("FAIL rst_mid_pre got v=%b %h exp v=1 41", sym_valid, sym_data); end
    resetn = 1'b0;
    step;
    vec++; if (sym_valid !== 1'b0 || sym_data !== 8'h00 || sym_first !== 1'b0 || sym_last !== 1'b0) begin
      miss++; $display("FAIL rst_mid_outputs got v=%b %h f=%b l=%b exp v=0 00 f=0 l=0", sym_valid, sym_data, sym_first, sym_last); end
    vec++; if (blk_count !== 2'd0 || blk_ready !== 1'b0) begin
      miss++; $display("FAIL rst_mid_fifo got cnt=%0d rdy=%b exp cnt=0 rdy=0", blk_count, blk_ready); end
    resetn = 1'b1;
    #1;
    vec++; if (blk_ready !== 1'b1) begin miss++; $display("FAIL rst_mid_ready got %b exp 1", blk_ready); end
    step; step; step;
    vec++; if (sym_valid !== 1'b0 || blk_count !== 2'd0) begin
      miss++; $display("FAIL rst_mid_no_resume got v=%b cnt=%0d exp v=0 cnt=0", sym_valid, blk_count); end
  endtask

`ifdef TX_SER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] exp_d;
    sym_ready = 1'b1;
    blk_valid = 1'b1; blk_data = {16{8'h01}};
    step;
    blk_data = 128'h3;
    step;
    blk_valid = 1'b0;
    for (int k = 0; k < 34; k++) begin
      if (k < 16)       exp_d = 8'h01;
      else if (k == 16) exp_d = 8'h00;
      else if (k == 17) exp_d = 8'h03;
      else if (k < 33)  exp_d = 8'h00;
      else              exp_d = 8'h03;
      vec++; if (sym_valid !== 1'b1 || sym_data !== exp_d) begin
        miss++; $display("FAIL csum_sym%0d got v=%b %h exp v=1 %h", k, sym_valid, sym_data, exp_d); end
      vec++; if (sym_first !== (k == 0 || k == 17) || sym_last !== (k == 16 || k == 33)) begin
        miss++; $display("FAIL csum_flags%0d got %b%b exp %b%b", k, sym_first, sym_last, k == 0 || k == 17, k == 16 || k == 33); end
      step;
    end
    vec++; if (sym_valid !== 1'b0) begin miss++; $display("FAIL csum_end got %b exp 0", sym_valid); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_fill;
    test_flush;
    test_reset_mid;
`ifdef TX_SER_CHECKSUM_EN
    test_checksum;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
